// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-channel UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_e;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityEven = 1;
  localparam int unsigned ParityOdd  = 2;

  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_ch.sv
// One UART transmit channel: byte FIFO, frame FSM and baud counter.
module uart_tx_ch
  import uart_pkg::*;
#(
  parameter int unsigned DIV         = 434,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       trans_done_o,
  output logic       ovf_o,
  output logic       txd_o
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]     wptr_q, rptr_q;
  logic            empty, full, push, pop;
  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [7:0]      data_q, data_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic            ovf_q;
  logic            bit_end, parity;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A write to a full FIFO still lands when a byte leaves on the same edge.
  assign push   = wr_en_i && (!full || pop);
  assign parity = (PARITY_MODE == ParityOdd) ? ~^data_q : ^data_q;
  assign bit_end = (cnt_q == CntMax);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    data_d  = data_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rptr_q[AW-1:0]];
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = (PARITY_MODE == ParityNone) ? StStop : StParity;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            if (!empty) begin
              pop     = 1'b1;
              data_d  = mem_q[rptr_q[AW-1:0]];
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    case (state_q)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = data_q[bit_q];
      StParity: txd_d = parity;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      ovf_q   <= wr_en_i && full && !pop;
    end
  end

  assign full_o       = full;
  assign busy_o       = (state_q != StIdle) || !empty || done_q;
  assign trans_done_o = done_q;
  assign ovf_o        = ovf_q;
  assign txd_o        = txd_q;

endmodule

// File: rtl/multi_uart_tx.sv
// Multi-channel UART transmitter: CH_NUM independent channels sharing one write port.
module multi_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                                       sys_clk,
  input  logic                                       sys_rst_n,
  input  logic                                       wr_en,
  input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] wr_ch,
  input  logic [7:0]                                 wr_data,
  output logic [CH_NUM-1:0]                          full,
  output logic [CH_NUM-1:0]                          busy,
  output logic [CH_NUM-1:0]                          trans_done,
  output logic [CH_NUM-1:0]                          ovf,
  output logic [CH_NUM-1:0]                          uart_txd
);

  localparam int unsigned ChW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned Div = calc_div(CLK_FREQ, BAUD);

  // Out-of-range channel numbers match no channel and are silently ignored.
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic sel;
    assign sel = wr_en && (wr_ch == ChW'(i));

    uart_tx_ch #(
      .DIV        (Div),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PARITY_MODE(PARITY_MODE),
      .STOP_BITS  (STOP_BITS)
    ) u_ch (
      .clk_i       (sys_clk),
      .rst_ni      (sys_rst_n),
      .wr_en_i     (sel),
      .wr_data_i   (wr_data),
      .full_o      (full[i]),
      .busy_o      (busy[i]),
      .trans_done_o(trans_done[i]),
      .ovf_o       (ovf[i]),
      .txd_o       (uart_txd[i])
    );
  end

endmodule

// File: tb/tb_multi_uart_tx.sv
// Bench: three DUTs (no parity/1 stop, even/2 stop, odd/1 stop) with a frame scoreboard.
module tb_multi_uart_tx;

  localparam int Div = 10;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] wr_en     = '0;
  logic [0:0] wr_ch     = '0;
  logic [7:0] wr_data   = '0;
  logic [1:0] full [3];
  logic [1:0] busy [3];
  logic [1:0] done [3];
  logic [1:0] ovf  [3];
  logic [1:0] txd  [3];
  logic [5:0] lines, dones;

  int n_vec = 0, n_err = 0, cyc = 0, wr_cyc = 0;
  int start_cyc [6];
  int end_cyc   [6];
  int frames    [6];
  int contig    [6];
  logic [7:0] exp_q [6][$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  assign lines = {txd[2], txd[1], txd[0]};
  assign dones = {done[2], done[1], done[0]};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multi_uart_tx #(
      .CLK_FREQ   (1_000_000),
      .BAUD       (100_000),
      .CH_NUM     (2),
      .FIFO_DEPTH (16),
      .PARITY_MODE(g),
      .STOP_BITS  ((g == 1) ? 2 : 1)
    ) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .wr_en     (wr_en[g]),
      .wr_ch     (wr_ch),
      .wr_data   (wr_data),
      .full      (full[g]),
      .busy      (busy[g]),
      .trans_done(done[g]),
      .ovf       (ovf[g]),
      .uart_txd  (txd[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line l = DUT l/2, channel l%2. Each start bit pops the expected byte.
  task automatic monitor(input int l);
    logic [11:0] eb;
    logic [7:0]  d;
    int nb, bad_line, bad_done;
    bit ab;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && lines[l] == 1'b0) begin
        start_cyc[l] = cyc;
        if (cyc == end_cyc[l] + 1) contig[l]++;
        check($sformatf("start_expected_l%0d", l), exp_q[l].size() > 0, 1);
        d = (exp_q[l].size() > 0) ? exp_q[l].pop_front() : 8'h00;
        eb = '1;
        eb[0] = 1'b0;
        eb[8:1] = d;
        nb = 9;
        if (l / 2 == 1) eb[nb++] = ^d;
        if (l / 2 == 2) eb[nb++] = ~^d;
        nb += (l / 2 == 1) ? 2 : 1;
        ab = 1'b0;
        for (int b = 0; b < nb && !ab; b++) begin
          bad_line = 0;
          bad_done = 0;
          for (int c = 0; c < Div; c++) begin
            if (b != 0 || c != 0) @(negedge sys_clk);
            if (!sys_rst_n) begin
              ab = 1'b1;
              break;
            end
            if (lines[l] !== eb[b]) bad_line++;
            if (dones[l] !== ((b == nb - 1) && (c == Div - 1))) bad_done++;
          end
          if (!ab) begin
            check($sformatf("line_l%0d_byte%0h_bit%0d_badcycles", l, d, b), bad_line, 0);
            check($sformatf("done_l%0d_byte%0h_bit%0d_badcycles", l, d, b), bad_done, 0);
          end
        end
        if (!ab) begin
          frames[l]++;
          end_cyc[l] = cyc;
        end
      end
    end
  endtask

  for (genvar l = 0; l < 6; l++) begin : g_mon
    initial monitor(l);
  end

  // Called at a negedge; the write lands on the next posedge.
  task automatic wr(input int inst, input int ch, input logic [7:0] d, input bit push);
    wr_en       = '0;
    wr_en[inst] = 1'b1;
    wr_ch       = 1'(ch);
    wr_data     = d;
    @(negedge sys_clk);
    wr_cyc = cyc;
    if (push) exp_q[inst * 2 + ch].push_back(d);
    wr_en = '0;
  endtask

  task automatic wait_idle(input string tag);
    int pending;
    for (int n = 0; n < 4000; n++) begin
      pending = 0;
      for (int l = 0; l < 6; l++) pending += exp_q[l].size();
      if (pending == 0 && busy[0] == 0 && busy[1] == 0 && busy[2] == 0) break;
      @(negedge sys_clk);
    end
    check({tag, "_idle_busy"}, {busy[2], busy[1], busy[0]}, 0);
    check({tag, "_idle_pending"}, pending, 0);
  endtask

  initial begin
    int f_before, c_before;
    for (int l = 0; l < 6; l++) begin
      start_cyc[l] = 0;
      end_cyc[l]   = -10;
      frames[l]    = 0;
      contig[l]    = 0;
    end

    // Reset state
    repeat (3) @(negedge sys_clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_txd_dut%0d", g), txd[g], 2'b11);
      check($sformatf("rst_flags_dut%0d", g), {full[g], busy[g], done[g], ovf[g]}, 0);
    end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 0x55 on ch0, no parity: start at write edge + 2
    wr(0, 0, 8'h55, 1'b1);
    check("busy_after_write", busy[0], 2'b01);
    @(negedge sys_clk);
    check("line_high_before_start", txd[0], 2'b11);
    wait_idle("f55");
    check("start_latency", start_cyc[0] - wr_cyc, 2);
    check("frames_ch0", frames[0], 1);
    check("frames_ch1_untouched", frames[1], 0);

    // Parity: 0x07 -> odd 0, even 1 (even DUT has two stop bits); 0x80 even -> 1
    wr(2, 0, 8'h07, 1'b1);
    wr(1, 0, 8'h07, 1'b1);
    wr(1, 1, 8'h80, 1'b1);
    wait_idle("parity");
    check("frames_odd", frames[4], 1);
    check("frames_even", frames[2] + frames[3], 2);

    // Two channels on consecutive cycles
    wr(0, 0, 8'hA5, 1'b1);
    wr(0, 1, 8'h3C, 1'b1);
    wait_idle("dual");
    check("ch1_start_offset", start_cyc[1] - start_cyc[0], 1);

    // Fill ch1 while it is framing: 16 queued, 17th dropped
    f_before = frames[1];
    c_before = contig[1];
    wr(0, 1, 8'hF0, 1'b1);
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 17; i++) begin
      wr(0, 1, 8'(i * 29 + 3), i < 16);
      if (i == 14) check("not_full_at_15", full[0][1], 1'b0);
      if (i == 15) check("full_at_16", full[0][1], 1'b1);
      if (i == 15) check("no_ovf_at_16", ovf[0][1], 1'b0);
      if (i == 16) check("ovf_on_17th", ovf[0], 2'b10);
    end
    @(negedge sys_clk);
    check("ovf_one_cycle", ovf[0][1], 1'b0);
    check("still_full", full[0][1], 1'b1);
    wait_idle("fill");
    check("fill_frames", frames[1] - f_before, 17);
    check("fill_back_to_back", contig[1] - c_before, 16);

    // Reset 35 cycles into a frame with another byte queued
    f_before = frames[0];
    wr(0, 0, 8'h5A, 1'b1);
    wr(0, 0, 8'h11, 1'b1);
    repeat (3) @(negedge sys_clk);
    for (int k = 0; k < 200 && cyc < start_cyc[0] + 35; k++) @(negedge sys_clk);
    check("reset_point", cyc - start_cyc[0], 35);
    #2 sys_rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("midrst_txd_dut%0d", g), txd[g], 2'b11);
      check($sformatf("midrst_busy_dut%0d", g), busy[g], 2'b00);
    end
    for (int l = 0; l < 6; l++) exp_q[l].delete();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (150) @(negedge sys_clk);
    check("post_rst_line", txd[0], 2'b11);
    check("post_rst_busy", busy[0], 2'b00);
    check("aborted_frame_not_done", frames[0] - f_before, 0);

    // Recovery after reset
    wr(0, 0, 8'hC3, 1'b1);
    wait_idle("recover");
    check("recover_frame", frames[0] - f_before, 1);
    check("recover_latency", start_cyc[0] - wr_cyc, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_uart_tx.md
MULTI_UART_TX -- requirements
Module: multi_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter CH_NUM, default 2, number of independent TX channels (1..8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, per-channel byte FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameter PARITY_MODE, default 0, parity setting: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop-bit count (1 or 2).
REQ-007 SHALL have port sys_clk, input, 1 bit, the single clock.
REQ-008 SHALL have port sys_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port wr_en, input, 1 bit, byte write strobe.
REQ-010 SHALL have port wr_ch, input, clog2(CH_NUM) bits (min 1), target channel.
REQ-011 SHALL have port wr_data, input, 8 bits, byte to queue.
REQ-012 SHALL have port full, output, CH_NUM bits, per-channel FIFO full.
REQ-013 SHALL have port busy, output, CH_NUM bits, channel is framing or FIFO non-empty.
REQ-014 SHALL have port trans_done, output, CH_NUM bits, one-cycle pulse per channel at end of last stop bit.
REQ-015 SHALL have port ovf, output, CH_NUM bits, one-cycle pulse when a write to a full channel is dropped.
REQ-016 SHALL have port uart_txd, output, CH_NUM bits, serial lines, idle high.

Function
REQ-017 SHALL use bit period DIV = CLK_FREQ/BAUD cycles (integer floor), with a per-channel counter restarted at each frame start.
REQ-018 SHALL run each channel FSM through IDLE -> START -> DATA (8 bits, LSB first) -> PARITY (skipped when PARITY_MODE=0) -> STOP (STOP_BITS periods) -> IDLE.
REQ-019 SHALL hold each bit on uart_txd for exactly DIV cycles.
REQ-020 SHALL compute parity over the 8 data bits: even = XOR of the bits; odd = inverted XOR.
REQ-021 SHALL write wr_data into FIFO[wr_ch] at the edge where wr_en=1 and full[wr_ch]=0.
REQ-022 SHALL drop the byte when wr_en=1 and full[wr_ch]=1, leave the FIFO unchanged, and pulse ovf[wr_ch] on the next cycle.
REQ-023 SHALL ignore a write when wr_ch>=CH_NUM, with no ovf pulse.
REQ-024 SHALL have a channel in IDLE with a non-empty FIFO pop one byte and drive uart_txd low from the following edge; a write at edge N into an empty idle channel gives the start bit at edge N+2.
REQ-025 SHALL, when the FIFO is non-empty at the end of STOP, go directly to the next START with no idle gap (back-to-back frames).
REQ-026 SHALL, on a simultaneous write and pop on the same channel, perform both, so occupancy is unchanged (also when full).
REQ-027 SHALL assert full when occupancy = FIFO_DEPTH, and SHALL handle pointer wrap-around correctly.
REQ-028 SHALL assert trans_done[i] for exactly one cycle at the final cycle of the last stop bit.
REQ-029 SHALL keep channels fully independent; one channel's activity SHALL NOT alter another channel's timing.

Reset
REQ-030 SHALL, while sys_rst_n=0 (asynchronous), force uart_txd to all 1, full/busy/trans_done/ovf to 0, FSMs to IDLE, FIFOs to empty, and counters to 0.
REQ-031 SHALL, on reset mid-frame, abort the frame immediately (line high), discard queued bytes, and resume with no glitch low after reset release.

Structure
REQ-032 SHALL place the FSM state encoding, the DIV constant function and the parity-mode constants in shared package uart_pkg.
REQ-033 SHALL implement one channel (FIFO + FSM + baud counter) as sub-module uart_tx_ch, instantiated CH_NUM times by generate.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10)
REQ-034 SHALL check: write 0x55 to ch0, PARITY_MODE=0 -> ch0 line low 10 cycles, then bits 1,0,1,0,1,0,1,0, then high 10 cycles; trans_done[0] pulses once, ch1 stays high.
REQ-035 SHALL check: PARITY_MODE=2, write 0x07 -> parity bit 0; PARITY_MODE=1 -> parity bit 1.
REQ-036 SHALL check: write 17 bytes to ch1 while busy (FIFO_DEPTH=16) -> full[1]=1 after 16 queued, ovf[1] pulses on the 17th; 16 frames are sent back-to-back with no idle gap.
REQ-037 SHALL check: write 0xA5 to ch0 and 0x3C to ch1 on consecutive cycles -> both frames are correct, with ch1 starting 1 cycle after ch0.
REQ-038 SHALL check: assert reset at cycle 35 of a frame -> uart_txd goes to all 1 immediately and busy goes to 0; after release, no output until the next write.
REQ-039 SHALL check: STOP_BITS=2 -> stop high for 20 cycles before trans_done.
